// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM pipeline register. Also holds the architectural NZCV flags
// (C fed back to the ALU) and a retired-instruction counter.
module exe_mem_stage_reg #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 4,
    parameter int CNT_LEN      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic                    s_bit,
    input  logic [DATA_LEN-1:0]     alu_res,
    input  logic                    alu_c,
    input  logic                    alu_v,
    input  logic                    alu_z,
    input  logic                    alu_n,
    input  logic [DATA_LEN-1:0]     val_rm,
    input  logic [REG_ADDR_LEN-1:0] dest,
    input  logic                    wb_en,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    output logic                    out_valid,
    output logic [DATA_LEN-1:0]     alu_res_q,
    output logic [DATA_LEN-1:0]     val_rm_q,
    output logic [REG_ADDR_LEN-1:0] dest_q,
    output logic                    wb_en_q,
    output logic                    mem_r_en_q,
    output logic                    mem_w_en_q,
    output logic [3:0]              status,
    output logic                    carry_flag,
    output logic [CNT_LEN-1:0]      retired_cnt
);

    logic                    r_valid;
    logic [DATA_LEN-1:0]     r_alu_res;
    logic [DATA_LEN-1:0]     r_val_rm;
    logic [REG_ADDR_LEN-1:0] r_dest;
    logic                    r_wb_en;
    logic                    r_mem_r_en;
    logic                    r_mem_w_en;
    logic [3:0]              r_status;
    logic [CNT_LEN-1:0]      r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_alu_res     <= '0;
            r_val_rm      <= '0;
            r_dest        <= '0;
            r_wb_en       <= 1'b0;
            r_mem_r_en    <= 1'b0;
            r_mem_w_en    <= 1'b0;
            r_status      <= 4'b0000;
            r_retired_cnt <= '0;
        end else if (flush) begin
            // Bubble: data regs keep stale contents, control is cleared.
            r_valid    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
        end else if (!freeze) begin
            r_valid    <= in_valid;
            r_alu_res  <= alu_res;
            r_val_rm   <= val_rm;
            r_dest     <= dest;
            r_wb_en    <= wb_en    & in_valid;
            r_mem_r_en <= mem_r_en & in_valid;
            r_mem_w_en <= mem_w_en & in_valid;
            if (in_valid)
                r_retired_cnt <= r_retired_cnt + 1'b1;
            if (in_valid && s_bit)
                r_status <= {alu_n, alu_z, alu_c, alu_v};
        end
    end

    assign out_valid   = r_valid;
    assign alu_res_q   = r_alu_res;
    assign val_rm_q    = r_val_rm;
    assign dest_q      = r_dest;
    assign wb_en_q     = r_wb_en;
    assign mem_r_en_q  = r_mem_r_en;
    assign mem_w_en_q  = r_mem_w_en;
    assign status      = r_status;
    assign carry_flag  = r_status[1];
    assign retired_cnt = r_retired_cnt;

endmodule
